// File: rtl/alu_core.sv
// 4-bit registered ALU: operands and opcode are sampled every clock and the
// result plus C/Z/N/V flags appear on registered outputs one edge later.
module alu_core (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] OPCODE,
    input  logic [3:0] OP1,
    input  logic [3:0] OP2,
    output logic [3:0] RESULT,
    output logic       C,
    output logic       Z,
    output logic       N,
    output logic       V
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

    opcode_e    op;
    logic [4:0] sum5;
    logic [4:0] diff5;
    logic [1:0] sh;
    logic [3:0] res_d;
    logic       c_d;
    logic       v_d;

    assign op    = opcode_e'(OPCODE);
    assign sum5  = {1'b0, OP1} + {1'b0, OP2};
    // Bit 4 of the zero-extended difference is set exactly when OP1 < OP2.
    assign diff5 = {1'b0, OP1} - {1'b0, OP2};
    assign sh    = OP2[1:0];

    always_comb begin
        res_d = 4'h0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_d = sum5[3:0];
                c_d   = sum5[4];
                v_d   = (OP1[3] == OP2[3]) && (sum5[3] != OP1[3]);
            end
            OP_SUB: begin
                res_d = diff5[3:0];
                c_d   = diff5[4];
                v_d   = (OP1[3] != OP2[3]) && (diff5[3] != OP1[3]);
            end
            OP_AND: res_d = OP1 & OP2;
            OP_OR:  res_d = OP1 | OP2;
            OP_XOR: res_d = OP1 ^ OP2;
            OP_NOT: res_d = ~OP1;
            OP_SHL: begin
                res_d = OP1 << sh;
                case (sh)
                    2'd1:    c_d = OP1[3];
                    2'd2:    c_d = OP1[2];
                    2'd3:    c_d = OP1[1];
                    default: c_d = 1'b0;
                endcase
            end
            OP_SHR: begin
                res_d = OP1 >> sh;
                case (sh)
                    2'd1:    c_d = OP1[0];
                    2'd2:    c_d = OP1[1];
                    2'd3:    c_d = OP1[2];
                    default: c_d = 1'b0;
                endcase
            end
            default: begin
                res_d = 4'h0;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
        endcase
    end

    // rstn is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rstn) begin
            RESULT <= 4'h0;
            C      <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
            V      <= 1'b0;
        end else begin
            RESULT <= res_d;
            C      <= c_d;
            Z      <= (res_d == 4'h0);
            N      <= res_d[3];
            V      <= v_d;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed table-driven bench for alu_core with hand-computed expectations,
// plus reset and back-to-back latency sequences.
module tb_alu_core;

    logic       clk;
    logic       rstn;
    logic [2:0] OPCODE;
    logic [3:0] OP1;
    logic [3:0] OP2;
    logic [3:0] RESULT;
    logic       C, Z, N, V;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      name;
        logic [2:0] opcode;
        logic [3:0] op1;
        logic [3:0] op2;
        logic [3:0] res;
        logic       c, z, n, v;
    } vec_t;

    vec_t vecs[$];

    alu_core dut (
        .clk    (clk),
        .rstn   (rstn),
        .OPCODE (OPCODE),
        .OP1    (OP1),
        .OP2    (OP2),
        .RESULT (RESULT),
        .C      (C),
        .Z      (Z),
        .N      (N),
        .V      (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [3:0] res, input logic c,
                         input logic z, input logic n, input logic v);
        logic [7:0] act, exp;
        act = {RESULT, C, Z, N, V};
        exp = {res, c, z, n, v};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got RESULT=%h C=%b Z=%b N=%b V=%b, expected RESULT=%h C=%b Z=%b N=%b V=%b",
                      name, act[7:4], act[3], act[2], act[1], act[0], res, c, z, n, v);
    endtask

    task automatic drive(input logic r, input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rstn   = r;
        OPCODE = opc;
        OP1    = a;
        OP2    = b;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            name          opc     op1   op2   res   c     z     n     v
        vecs.push_back('{"add_7_1",  3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"add_f_1",  3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"add_8_8",  3'b000, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"add_4_4",  3'b000, 4'h4, 4'h4, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"sub_3_5",  3'b001, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_8_1",  3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_0_0",  3'b001, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_f_1",  3'b001, 4'hF, 4'h1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"and_a_c",  3'b010, 4'hA, 4'hC, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"or_a_c",   3'b011, 4'hA, 4'hC, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"xor_a_c",  3'b100, 4'hA, 4'hC, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"not_a",    3'b101, 4'hA, 4'hC, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"not_0",    3'b101, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"shl_9_1",  3'b110, 4'h9, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"shr_9_6",  3'b111, 4'h9, 4'h6, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"shl_9_0",  3'b110, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"shr_9_c",  3'b111, 4'h9, 4'hC, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"shl_5_3",  3'b110, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"shr_5_7",  3'b111, 4'h5, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"shr_e_1",  3'b111, 4'hE, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0});

        rstn = 1'b1; OPCODE = 3'b111; OP1 = 4'h0; OP2 = 4'hF;

        // Reset for two edges, then release with the same inputs: 0 >> 3 = 0.
        post_edge();
        post_edge();
        check("reset_state", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b111, 4'h0, 4'hF);
        post_edge();
        check("first_after_reset", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream: a new vector each cycle, each result one edge later,
        // and the previous result still held just before the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b0, vecs[i].opcode, vecs[i].op1, vecs[i].op2);
            if (i > 0)
                check({vecs[i].name, "_hold_prev"}, vecs[i-1].res, vecs[i-1].c,
                      vecs[i-1].z, vecs[i-1].n, vecs[i-1].v);
            post_edge();
            check(vecs[i].name, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v);
        end

        // Reset asserted mid-stream overrides the operation on that edge.
        drive(1'b0, 3'b000, 4'hF, 4'hF);
        post_edge();
        check("pre_mid_reset_add", 4'hE, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b000, 4'h7, 4'h1);
        post_edge();
        check("mid_reset_clears", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b100, 4'h3, 4'h5);
        post_edge();
        check("after_mid_reset_xor", 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'b001, 4'h7, 4'h8);
        post_edge();
        check("sub_7_8_overflow", 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
